// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over CH unsigned channels with signed per-channel kernels, summed across channels.
// Latency: 3 clocks from the accepting edge to data_out_en, fixed regardless of input gaps.
// Backpressure: none; the engine accepts a pixel on every data_in_en cycle and never stalls the source.
//
// Ports:
//   clk, rst              pixel clock, asynchronous active-high reset
//   data_in_en/_sof       pixel valid and frame start (sof only counts when data_in_en=1)
//   data_in               CH packed pixels, channel 0 in the LSBs
//   coe                   CH*9 signed taps; channel c tap (r,k) at (c*9+r*3+k)*COE_W, r/k=0 is oldest
//   data_out(_en/_sof/_eol) shifted, saturated result with its valid and frame/line markers
module conv3x3_stream #(
   parameter int DATA_W = 16,
   parameter int COE_W  = 4,
   parameter int CH     = 3,
   parameter int IMG_W  = 480,
   parameter int SHIFT  = 0,
   parameter int OUT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      data_in_en,
   input  logic                      data_in_sof,
   input  logic [CH*DATA_W-1:0]      data_in,
   input  logic [CH*9*COE_W-1:0]     coe,
   output logic [OUT_W-1:0]          data_out,
   output logic                      data_out_en,
   output logic                      data_out_sof,
   output logic                      data_out_eol
);

   localparam int PROD_W = DATA_W + COE_W + 1;
   localparam int ACC_W  = DATA_W + COE_W + 6;
   localparam int COL_W  = $clog2(IMG_W);
   localparam int NTAP   = CH * 9;
   localparam int PIX_W  = CH * DATA_W;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [15:0]      ROW_TWO  = 16'd2;
   localparam logic [15:0]      ROW_MAX  = 16'hFFFF;

   // ------------------------------------------------------------------
   // Position tracking
   // ------------------------------------------------------------------
   logic [COL_W-1:0] col;
   logic [15:0]      row;
   logic [COL_W-1:0] cur_col;
   logic [15:0]      cur_row;
   logic             framed;       // a sof has been seen since reset
   logic             win_ok;

   // A sof pixel restarts the frame on the very pixel that carries it.
   assign cur_col = data_in_sof ? '0 : col;
   assign cur_row = data_in_sof ? '0 : row;

   // framed keeps a reset that lands mid-frame from restarting output on stale lines.
   assign win_ok = data_in_en && (framed || data_in_sof) &&
                   (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

   logic [NTAP*COE_W-1:0] coe_sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col    <= '0;
         row    <= '0;
         framed <= 1'b0;
         coe_sh <= '0;
      end else if (data_in_en) begin
         if (data_in_sof) begin
            framed <= 1'b1;
            coe_sh <= coe;
         end
         if (cur_col == LAST_COL) begin
            col <= '0;
            row <= (cur_row == ROW_MAX) ? cur_row : cur_row + 16'd1;
         end else begin
            col <= cur_col + COL_W'(1);
            row <= cur_row;
         end
      end
   end

   // ------------------------------------------------------------------
   // Line buffers: lb_near holds the previous line, lb_far the one before.
   // Contents need no reset; the window is only trusted after two fresh lines.
   // ------------------------------------------------------------------
   logic [PIX_W-1:0] lb_near [IMG_W];
   logic [PIX_W-1:0] lb_far  [IMG_W];
   logic [PIX_W-1:0] up1;
   logic [PIX_W-1:0] up2;

   assign up1 = lb_near[cur_col];
   assign up2 = lb_far[cur_col];

   always_ff @(posedge clk) begin
      if (data_in_en) begin
         lb_near[cur_col] <= data_in;
         lb_far[cur_col]  <= up1;
      end
   end

   // ------------------------------------------------------------------
   // Stage 0: 3x3 window, win[r][k] with r=0 oldest row, k=0 oldest column
   // ------------------------------------------------------------------
   logic [PIX_W-1:0] win [3][3];
   logic             v0, sof0, eol0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
               win[r][k] <= '0;
            end
         end
         v0   <= 1'b0;
         sof0 <= 1'b0;
         eol0 <= 1'b0;
      end else begin
         if (data_in_en) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= up2;
            win[1][2] <= up1;
            win[2][2] <= data_in;
         end
         v0   <= win_ok;
         sof0 <= win_ok && (cur_row == ROW_TWO) && (cur_col == COL_TWO);
         eol0 <= win_ok && (cur_col == LAST_COL);
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: per-tap products (unsigned pixel times signed coefficient)
   // ------------------------------------------------------------------
   function automatic logic signed [PROD_W-1:0] tap_mul(
      input logic [DATA_W-1:0] pix,
      input logic [COE_W-1:0]  k
   );
      logic signed [PROD_W-1:0] a;
      logic signed [PROD_W-1:0] b;
      a = signed'({{(PROD_W-DATA_W){1'b0}}, pix});
      b = signed'({{(PROD_W-COE_W){k[COE_W-1]}}, k});
      // The exact product fits in PROD_W bits, so truncation loses nothing.
      return a * b;
   endfunction

   logic signed [PROD_W-1:0] prod [NTAP];
   logic                     v1, sof1, eol1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NTAP; i++) begin
            prod[i] <= '0;
         end
         v1   <= 1'b0;
         sof1 <= 1'b0;
         eol1 <= 1'b0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 3; r++) begin
               for (int k = 0; k < 3; k++) begin
                  prod[c*9 + r*3 + k] <= tap_mul(win[r][k][c*DATA_W +: DATA_W],
                                                 coe_sh[(c*9 + r*3 + k)*COE_W +: COE_W]);
               end
            end
         end
         v1   <= v0;
         sof1 <= sof0;
         eol1 <= eol0;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: sum of all taps across all channels
   // ------------------------------------------------------------------
   logic signed [ACC_W-1:0] sum_c;
   logic signed [ACC_W-1:0] sum_r;
   logic                    v2, sof2, eol2;

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NTAP; i++) begin
         sum_c = sum_c + signed'({{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r <= '0;
         v2    <= 1'b0;
         sof2  <= 1'b0;
         eol2  <= 1'b0;
      end else begin
         sum_r <= sum_c;
         v2    <= v1;
         sof2  <= sof1;
         eol2  <= eol1;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: arithmetic shift, clamp to [0, 2^OUT_W-1], register output
   // ------------------------------------------------------------------
   logic signed [ACC_W-1:0] shifted;
   logic [OUT_W-1:0]        sat_c;

   assign shifted = sum_r >>> SHIFT;

   if (ACC_W - 1 > OUT_W) begin : g_clip
      always_comb begin
         sat_c = shifted[OUT_W-1:0];
         if (shifted[ACC_W-1]) begin
            sat_c = '0;
         end else if (|shifted[ACC_W-2:OUT_W]) begin
            sat_c = '1;
         end
      end
   end else begin : g_fit
      // Every non-negative sum already fits in the output width.
      always_comb begin
         sat_c = '0;
         if (!shifted[ACC_W-1]) begin
            sat_c = OUT_W'(shifted[ACC_W-2:0]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out     <= '0;
         data_out_en  <= 1'b0;
         data_out_sof <= 1'b0;
         data_out_eol <= 1'b0;
      end else begin
         data_out     <= v2 ? sat_c : '0;
         data_out_en  <= v2;
         data_out_sof <= v2 && sof2;
         data_out_eol <= v2 && eol2;
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: two instances (CH=3/SHIFT=0 and CH=1/SHIFT=3) share one pixel stream.
// Each accepted pixel is stored in a frame image; windows are convolved directly from that image.
// Expected results are queued with the cycle they must appear on and compared every clock.
module tb_conv3x3_stream;

   localparam int IMG_W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic          sof = 1'b0;
   logic [47:0]   din = '0;
   logic [107:0]  coe_a = '0;
   logic [35:0]   coe_b = '0;

   logic [15:0]   out_a, out_b;
   logic          en_a, sof_a, eol_a;
   logic          en_b, sof_b, eol_b;

   always #5 clk = ~clk;

   conv3x3_stream #(.DATA_W(16), .COE_W(4), .CH(3), .IMG_W(IMG_W), .SHIFT(0), .OUT_W(16)) u_a (
      .clk(clk), .rst(rst), .data_in_en(en), .data_in_sof(sof), .data_in(din), .coe(coe_a),
      .data_out(out_a), .data_out_en(en_a), .data_out_sof(sof_a), .data_out_eol(eol_a));

   conv3x3_stream #(.DATA_W(16), .COE_W(4), .CH(1), .IMG_W(IMG_W), .SHIFT(3), .OUT_W(16)) u_b (
      .clk(clk), .rst(rst), .data_in_en(en), .data_in_sof(sof), .data_in(din[15:0]), .coe(coe_b),
      .data_out(out_b), .data_out_en(en_b), .data_out_sof(sof_b), .data_out_eol(eol_b));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct {
      int cyc;
      int val;
      bit fs;
      bit fe;
   } exp_t;

   exp_t         qa[$];
   exp_t         qb[$];
   int           cyc = 0;
   bit           m_framed = 0;
   int           m_row = 0;
   int           m_col = 0;
   logic [47:0]  img[int];
   logic [107:0] sh_a = '0;
   logic [35:0]  sh_b = '0;

   function automatic int conv(input logic [107:0] cv, input int nch, input int shift,
                               input int r0, input int c0);
      int s;
      logic [47:0] p;
      logic [3:0]  t;
      s = 0;
      for (int c = 0; c < nch; c++) begin
         for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
               p = img[(r0 - 2 + r) * IMG_W + (c0 - 2 + k)];
               t = cv[(c*9 + r*3 + k)*4 +: 4];
               s += int'(p[c*16 +: 16]) * int'($signed(t));
            end
         end
      end
      s = s >>> shift;
      if (s < 0) return 0;
      if (s > 65535) return 65535;
      return s;
   endfunction

   always @(posedge clk) begin
      int   r, c;
      exp_t e;
      cyc++;
      if (rst) begin
         qa.delete();
         qb.delete();
         m_framed = 0;
         m_row = 0;
         m_col = 0;
      end else if (en) begin
         r = sof ? 0 : m_row;
         c = sof ? 0 : m_col;
         if (sof) begin
            m_framed = 1;
            sh_a = coe_a;
            sh_b = coe_b;
            img.delete();
         end
         img[r * IMG_W + c] = din;
         if (m_framed && r >= 2 && c >= 2) begin
            e.cyc = cyc + 3;
            e.fs  = (r == 2 && c == 2);
            e.fe  = (c == IMG_W - 1);
            e.val = conv(sh_a, 3, 0, r, c);
            qa.push_back(e);
            e.val = conv({72'b0, sh_b}, 1, 3, r, c);
            qb.push_back(e);
         end
         if (c == IMG_W - 1) begin
            m_col = 0;
            m_row = r + 1;
         end else begin
            m_col = c + 1;
            m_row = r;
         end
      end
      #2;
      if (qa.size() > 0 && qa[0].cyc == cyc) begin
         e = qa.pop_front();
         chk("a_en", en_a, 1);
         chk("a_dat", out_a, e.val);
         chk("a_sof", sof_a, e.fs);
         chk("a_eol", eol_a, e.fe);
      end else begin
         chk("a_en_idle", en_a, 0);
         chk("a_flags_idle", {sof_a, eol_a}, 0);
      end
      if (qb.size() > 0 && qb[0].cyc == cyc) begin
         e = qb.pop_front();
         chk("b_en", en_b, 1);
         chk("b_dat", out_b, e.val);
         chk("b_sof", sof_b, e.fs);
         chk("b_eol", eol_b, e.fe);
      end else begin
         chk("b_en_idle", en_b, 0);
         chk("b_flags_idle", {sof_b, eol_b}, 0);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   int kval = 0;

   function automatic logic [107:0] mk(input int nch, input logic [35:0] k9);
      logic [107:0] v;
      v = '0;
      for (int c = 0; c < nch; c++) v[c*36 +: 36] = k9;
      return v;
   endfunction

   function automatic logic [47:0] pix(input int mode, input int c);
      logic [15:0] v;
      if (mode == 2) return {16'($urandom), 32'($urandom)};
      v = (mode == 0) ? 16'(kval) : 16'(c);
      return {v, v, v};
   endfunction

   task automatic drive(input bit s, input logic [47:0] d, input int gaps);
      for (int i = 0; i < gaps; i++) begin
         @(negedge clk);
         en  = 1'b0;
         sof = 1'($urandom);
         din = {16'($urandom), 32'($urandom)};
      end
      @(negedge clk);
      en  = 1'b1;
      sof = s;
      din = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en  = 1'b0;
         sof = 1'b0;
      end
   endtask

   // gmode: 0 continuous, 1 alternate valid/idle, 2 random gaps
   task automatic frame(input int npix, input int mode, input int gmode, input bit with_sof);
      int g;
      for (int i = 0; i < npix; i++) begin
         g = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
         drive(with_sof && i == 0, pix(mode, i % IMG_W), g);
      end
   endtask

   localparam logic [35:0] K_ONE  = 36'h111111111;
   localparam logic [35:0] K_TWO  = 36'h222222222;
   localparam logic [35:0] K_SVN  = 36'h777777777;
   localparam logic [35:0] K_NEG  = 36'hFFFFFFFFF;
   localparam logic [35:0] K_SOBX = 36'h10F20E10F;
   localparam logic [35:0] K_SOBY = 36'hFEF000121;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_a_en", en_a, 0);
      chk("rst_a_dat", out_a, 0);
      chk("rst_a_flags", {sof_a, eol_a}, 0);
      chk("rst_b_en", en_b, 0);
      chk("rst_b_dat", out_b, 0);
      rst = 1'b0;

      // constant 10, all taps 1: a=270, b=90>>3=11
      coe_a = mk(3, K_ONE); coe_b = K_ONE; kval = 10;
      frame(4 * IMG_W, 0, 0, 1); idle(5);

      // Sobel-x / Sobel-y on a column ramp, channel 0 only on a
      coe_a = mk(1, K_SOBX); coe_b = K_SOBX;
      frame(4 * IMG_W, 1, 0, 1); idle(5);
      coe_a = mk(1, K_SOBY); coe_b = K_SOBY;
      frame(3 * IMG_W, 1, 0, 1); idle(5);

      // saturation high and negative clamp
      coe_a = mk(3, K_SVN); coe_b = K_SVN; kval = 65535;
      frame(3 * IMG_W, 0, 0, 1); idle(5);
      coe_a = mk(3, K_NEG); coe_b = K_NEG; kval = 5;
      frame(3 * IMG_W, 0, 0, 1); idle(5);

      // shift with alternating valid: b = 72>>3 = 9
      coe_a = mk(1, K_ONE); coe_b = K_ONE; kval = 8;
      frame(3 * IMG_W, 0, 1, 1); idle(5);

      // coefficient change mid-frame only takes effect at next sof
      coe_a = mk(1, K_ONE); coe_b = K_ONE; kval = 10;
      frame(3 * IMG_W, 0, 0, 1);
      coe_a = mk(1, K_TWO); coe_b = K_TWO;
      frame(2 * IMG_W, 0, 0, 0);
      frame(3 * IMG_W, 0, 0, 1); idle(5);

      // reset pulse during row 3, resume without sof, then with sof
      coe_a = mk(3, K_ONE); coe_b = K_ONE; kval = 3;
      frame(3 * IMG_W + 3, 0, 0, 1);
      @(negedge clk);
      en = 1'b0; rst = 1'b1;
      #1;
      chk("rst_mid_a_en", en_a, 0);
      chk("rst_mid_a_dat", out_a, 0);
      chk("rst_mid_b_en", en_b, 0);
      @(negedge clk);
      rst = 1'b0;
      frame(3 * IMG_W, 0, 0, 0); idle(5);
      frame(3 * IMG_W, 0, 0, 1); idle(5);

      // random coefficients, pixels, gaps and mid-line restarts
      for (int f = 0; f < 8; f++) begin
         coe_a = {$urandom, $urandom, $urandom, 12'($urandom)};
         coe_b = {4'($urandom), $urandom};
         frame(IMG_W * int'($urandom_range(2, 5)) + int'($urandom_range(0, IMG_W - 1)), 2, 2, 1);
      end
      idle(8);

      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
